uart_apb_regs: RTL and testbench
================================

UART_APB_REGS -- requirements
Module: uart_apb_regs

Interface
REQ-001 Clocking SHALL be one clock with a synchronous, active-high reset. PRESET is sampled only on the rising edge of PCLK.
REQ-002 Parameter: RD_TIMEOUT, default 4, is the maximum number of WAIT cycles for rx_data_read_valid.
REQ-003 PCLK  in  1  system/APB clock.
REQ-004 PRESET  in  1  synchronous active-high reset.
REQ-005 PSEL, PENABLE, PWRITE  in  1 each  APB3 control.
REQ-006 PADDR  in  5  byte address; only [4:2] decoded.
REQ-007 PWDATA  in  32  write data.
REQ-008 PRDATA  out  32  read data.
REQ-009 PREADY, PSLVERR  out  1 each  APB3 response.
REQ-010 rx_data  in  8  popped RX byte, meaningful only while rx_data_read_valid=1.
REQ-011 rx_data_read_valid, rx_ready, parity_err, overflow  in  1 each  receiver status; overflow is a one-cycle pulse.
REQ-012 rx_data_reg_rd  out  1  one-cycle pop request to the receiver FIFO.
REQ-013 data_bits, parity_en, parity_odd0_even1  out  1 each  receiver configuration, driven from CTRL.
REQ-014 irq  out  1  level interrupt.

Function
REQ-015 Register map SHALL be:
  - 0x00 RXDATA (RO): [7:0] data, [8] valid.
  - 0x04 CTRL (RW): [0] data_bits (1 = 8 bits, 0 = 7 bits), [1] parity_en, [2] parity_odd0_even1.
  - 0x08 STATUS: [0] rx_ready (live, RO), [1] ovf (sticky, W1C), [2] perr (sticky, W1C).
  - 0x0C INTEN (RW): bits [2:0].
REQ-016 Unmapped offsets 0x10–0x1C SHALL complete with PSLVERR=1 and PRDATA=0, and writes to them SHALL be ignored. Unused register bits SHALL read 0.
REQ-017 FSM states SHALL be IDLE, WAIT, DONE.
REQ-018 All accesses other than an RXDATA read SHALL complete in the access cycle with PREADY=1 (zero wait states), and the FSM SHALL stay in IDLE.
REQ-019 RXDATA read setup cycle (PSEL=1, PENABLE=0, PWRITE=0, offset 0x00):
  - if rx_ready=1: assert rx_data_reg_rd for exactly that cycle and go to WAIT;
  - if rx_ready=0: no pop; the access completes in 0 wait states with PRDATA=0.
REQ-020 In WAIT, PREADY SHALL be 0. On rx_data_read_valid=1, capture {1'b1, rx_data} into the read-hold register and go to DONE.
REQ-021 If WAIT lasts RD_TIMEOUT cycles without rx_data_read_valid, go to DONE with the error flag set.
REQ-022 In DONE with PENABLE=1:
  - drive PREADY=1;
  - drive PRDATA = hold register, or 0 if the error flag is set;
  - drive PSLVERR = error flag;
  - return to IDLE on the next cycle.
REQ-023 If PSEL=0 in WAIT or DONE (protocol abort), the FSM SHALL return to IDLE and discard captured data; the pop already issued is not retried.
REQ-024 rx_data_read_valid outside WAIT SHALL be ignored.
REQ-025 Writes to RXDATA SHALL be ignored with PSLVERR=0.
REQ-026 STATUS.ovf SHALL be set on any cycle overflow=1, and STATUS.perr on any cycle parity_err=1. If a set and a W1C hit the same bit in the same cycle, set wins.
REQ-027 irq SHALL equal |(STATUS[2:0] & INTEN[2:0]), registered with one cycle of latency.
REQ-028 A CTRL write SHALL take effect on the configuration outputs on the cycle after the access cycle.
REQ-029 PRDATA SHALL be 0 whenever PREADY=0 or PSEL=0.

Reset
REQ-030 While PRESET=1, the following SHALL be forced:
  - FSM = IDLE;
  - CTRL = 0x1 (8 data bits, no parity);
  - STATUS sticky bits = 0, INTEN = 0, hold register = 0, error flag = 0;
  - rx_data_reg_rd = 0, irq = 0, PRDATA = 0, PSLVERR = 0, PREADY = 1.
REQ-031 Reset asserted in WAIT SHALL abandon the read without issuing a further pop.

Configuration
REQ-032 With macro UART_REGS_IRQ_EN defined, INTEN and the irq logic SHALL be present as in REQ-027.
REQ-033 Without UART_REGS_IRQ_EN, irq SHALL be tied to 0, INTEN SHALL read 0 and ignore writes, and STATUS behaviour SHALL be unchanged.

Structure
REQ-034 Shared package uart_pkg SHALL hold the register offsets, STATUS/CTRL/INTEN bit positions, FSM state encodings and the RD_TIMEOUT default.
REQ-035 The RXDATA pop/wait FSM, including the timeout counter and hold register, SHALL be the single sub-module uart_apb_rd_ctrl. Register storage and decode remain in uart_apb_regs.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
  - Read CTRL after reset -> PRDATA=0x1, PREADY=1 in the access cycle, PSLVERR=0.
  - rx_ready=1, RXDATA read, rx_data=0xA5 with valid 2 cycles after the pop -> one rx_data_reg_rd pulse, PRDATA=0x1A5, 2 wait states.
  - rx_ready=0, RXDATA read -> no pop, PRDATA=0x000, 0 wait states.
  - Pop issued, valid never arrives -> PSLVERR=1, PRDATA=0 after 4 wait states, FSM back in IDLE.
  - overflow pulse in the same cycle as W1C 0x2 to STATUS -> STATUS.ovf stays 1; with INTEN=0x2, irq=1 one cycle later.
  - Read offset 0x14 -> PSLVERR=1, PRDATA=0; PRESET asserted in WAIT -> IDLE, rx_data_reg_rd=0 thereafter.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Register offsets, bit positions and read-FSM states for the UART APB block.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int unsigned c_rd_timeout_default = 4;

  // Word offsets, i.e. PADDR[4:2]
  localparam logic [2:0] c_off_rxdata = 3'd0;
  localparam logic [2:0] c_off_ctrl   = 3'd1;
  localparam logic [2:0] c_off_status = 3'd2;
  localparam logic [2:0] c_off_inten  = 3'd3;

  localparam int c_reg_w = 3;

  localparam int c_ctrl_data_bits         = 0;
  localparam int c_ctrl_parity_en         = 1;
  localparam int c_ctrl_parity_odd0_even1 = 2;
  localparam logic [c_reg_w-1:0] c_ctrl_reset = 3'b001;

  // INTEN shares the STATUS bit positions
  localparam int c_stat_rx_ready = 0;
  localparam int c_stat_ovf      = 1;
  localparam int c_stat_perr     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } rd_state_e;

  function automatic logic reg_is_mapped(input logic [2:0] off);
    return (off[2] == 1'b0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_apb_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_apb_rd_ctrl
// Brief    : RXDATA pop/wait FSM with timeout counter and read-hold register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_apb_rd_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT = c_rd_timeout_default
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       rd_setup,
  input  logic       psel,
  input  logic       penable,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_data_read_valid,
  output logic       rx_data_reg_rd,
  output logic       rd_wait,
  output logic       rd_done,
  output logic [8:0] rd_hold,
  output logic       rd_err
);

  localparam int unsigned c_cnt_w = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(RD_TIMEOUT - 1);

  rd_state_e          r_state;
  rd_state_e          w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [8:0]         r_hold;
  logic [8:0]         w_hold_nxt;
  logic               r_err;
  logic               w_err_nxt;
  logic               w_pop;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hold  <= w_hold_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold_nxt  = r_hold;
    w_err_nxt   = r_err;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rd_setup && rx_ready && !PRESET) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = '0;
          w_hold_nxt  = '0;
          w_err_nxt   = 1'b0;
        end
      end
      ST_WAIT: begin
        // Abort drops the transfer; the byte already popped is lost by design
        if (!psel) begin
          w_state_nxt = ST_IDLE;
          w_hold_nxt  = '0;
          w_err_nxt   = 1'b0;
        end else if (rx_data_read_valid) begin
          w_hold_nxt  = {1'b1, rx_data};
          w_state_nxt = ST_DONE;
        end else if (r_cnt == c_cnt_last) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        if (!psel || penable) begin
          w_state_nxt = ST_IDLE;
          w_hold_nxt  = '0;
          w_err_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign rx_data_reg_rd = w_pop;
  assign rd_wait        = (r_state == ST_WAIT);
  assign rd_done        = (r_state == ST_DONE);
  assign rd_hold        = r_hold;
  assign rd_err         = r_err;

endmodule
`default_nettype wire

// File: rtl/uart_apb_regs.sv
`default_nettype none
// ============================================================================
// Module   : uart_apb_regs
// Brief    : APB3 register block for a UART receiver; INTEN/irq exist only
//            when UART_REGS_IRQ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_apb_regs
  import uart_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT = c_rd_timeout_default
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [4:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_read_valid,
  input  logic        rx_ready,
  input  logic        parity_err,
  input  logic        overflow,
  output logic        rx_data_reg_rd,
  output logic        data_bits,
  output logic        parity_en,
  output logic        parity_odd0_even1,
  output logic        irq
);

  logic [2:0]         w_off;
  logic               w_access;
  logic               w_rd_setup;
  logic               w_wr;
  logic               w_wr_ctrl;
  logic               w_wr_status;
  logic               w_wr_inten;
  logic               w_rd_wait;
  logic               w_rd_done;
  logic [8:0]         w_rd_hold;
  logic               w_rd_err;
  logic [c_reg_w-1:0] r_ctrl;
  logic               r_ovf;
  logic               r_perr;
  logic [c_reg_w-1:0] w_status;
  logic [c_reg_w-1:0] w_inten;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_off       = PADDR[4:2];
  assign w_access    = PSEL & PENABLE;
  assign w_rd_setup  = PSEL & ~PENABLE & ~PWRITE & (w_off == c_off_rxdata);
  assign w_wr        = w_access & PWRITE & ~w_rd_wait & ~w_rd_done;
  assign w_wr_ctrl   = w_wr & (w_off == c_off_ctrl);
  assign w_wr_status = w_wr & (w_off == c_off_status);
  assign w_wr_inten  = w_wr & (w_off == c_off_inten);
  assign w_unused    = &{1'b0, PWDATA[31:3], PADDR[1:0]};

  uart_apb_rd_ctrl #(
    .RD_TIMEOUT (RD_TIMEOUT)
  ) u_rd_ctrl (
    .PCLK               (PCLK),
    .PRESET             (PRESET),
    .rd_setup           (w_rd_setup),
    .psel               (PSEL),
    .penable            (PENABLE),
    .rx_ready           (rx_ready),
    .rx_data            (rx_data),
    .rx_data_read_valid (rx_data_read_valid),
    .rx_data_reg_rd     (rx_data_reg_rd),
    .rd_wait            (w_rd_wait),
    .rd_done            (w_rd_done),
    .rd_hold            (w_rd_hold),
    .rd_err             (w_rd_err)
  );

  // Sticky flags: a same-cycle hardware set overrides the W1C
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_ctrl <= c_ctrl_reset;
      r_ovf  <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl <= PWDATA[c_reg_w-1:0];
      end
      r_ovf  <= (r_ovf  & ~(w_wr_status & PWDATA[c_stat_ovf]))  | overflow;
      r_perr <= (r_perr & ~(w_wr_status & PWDATA[c_stat_perr])) | parity_err;
    end
  end

  always_comb begin
    w_status                  = '0;
    w_status[c_stat_rx_ready] = rx_ready;
    w_status[c_stat_ovf]      = r_ovf;
    w_status[c_stat_perr]     = r_perr;
  end

`ifdef UART_REGS_IRQ_EN
  logic [c_reg_w-1:0] r_inten;
  logic               r_irq;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_inten <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr_inten) begin
        r_inten <= PWDATA[c_reg_w-1:0];
      end
      r_irq <= |(w_status & r_inten);
    end
  end

  assign w_inten = r_inten;
  assign irq     = r_irq & ~PRESET;
`else
  logic w_unused_inten;
  assign w_unused_inten = w_wr_inten;
  assign w_inten        = '0;
  assign irq            = 1'b0;
`endif

  assign data_bits         = r_ctrl[c_ctrl_data_bits] | PRESET;
  assign parity_en         = r_ctrl[c_ctrl_parity_en] & ~PRESET;
  assign parity_odd0_even1 = r_ctrl[c_ctrl_parity_odd0_even1] & ~PRESET;

  always_comb begin
    w_rdata = '0;
    case (w_off)
      c_off_ctrl:   w_rdata[c_reg_w-1:0] = r_ctrl;
      c_off_status: w_rdata[c_reg_w-1:0] = w_status;
      c_off_inten:  w_rdata[c_reg_w-1:0] = w_inten;
      default:      w_rdata = '0;
    endcase
  end

  // An RXDATA read that did not pop stays in IDLE and returns zero via w_rdata
  always_comb begin
    PREADY  = 1'b1;
    PRDATA  = '0;
    PSLVERR = 1'b0;
    if (!PRESET) begin
      if (w_rd_wait) begin
        PREADY = 1'b0;
      end else if (w_rd_done) begin
        if (w_access) begin
          PSLVERR = w_rd_err;
          if (!w_rd_err) begin
            PRDATA[8:0] = w_rd_hold;
          end
        end
      end else if (w_access) begin
        PSLVERR = ~reg_is_mapped(w_off);
        if (!PWRITE) begin
          PRDATA = w_rdata;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_apb_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_apb_regs
// Brief    : Scoreboard bench for uart_apb_regs with a behavioural register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_apb_regs;
  import uart_pkg::*;

  localparam int unsigned c_rd_to = 4;
`ifdef UART_REGS_IRQ_EN
  localparam bit c_irq_en = 1'b1;
`else
  localparam bit c_irq_en = 1'b0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [4:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [7:0]  rx_data = '0;
  logic        rx_data_read_valid = 1'b0;
  logic        rx_ready = 1'b0;
  logic        parity_err = 1'b0;
  logic        overflow = 1'b0;
  logic        rx_data_reg_rd;
  logic        data_bits;
  logic        parity_en;
  logic        parity_odd0_even1;
  logic        irq;

  uart_apb_regs #(.RD_TIMEOUT(c_rd_to)) dut (
    .PCLK               (PCLK),
    .PRESET             (PRESET),
    .PSEL               (PSEL),
    .PENABLE            (PENABLE),
    .PWRITE             (PWRITE),
    .PADDR              (PADDR),
    .PWDATA             (PWDATA),
    .PRDATA             (PRDATA),
    .PREADY             (PREADY),
    .PSLVERR            (PSLVERR),
    .rx_data            (rx_data),
    .rx_data_read_valid (rx_data_read_valid),
    .rx_ready           (rx_ready),
    .parity_err         (parity_err),
    .overflow           (overflow),
    .rx_data_reg_rd     (rx_data_reg_rd),
    .data_bits          (data_bits),
    .parity_en          (parity_en),
    .parity_odd0_even1  (parity_odd0_even1),
    .irq                (irq)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    string       name;
    bit          is_read;
    logic [31:0] rdata;
    logic        slverr;
    int          waits;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          rx_lat = 0;
  int          obs_pops = 0;
  int          m_pops = 0;
  logic [2:0]  m_ctrl = 3'b001;
  logic [2:0]  m_inten = 3'b000;
  logic        m_ovf = 1'b0;
  logic        m_perr = 1'b0;
  int          mon_waits = 0;
  exp_t        mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic exp_irq();
    return c_irq_en && (|({m_perr, m_ovf, rx_ready} & m_inten));
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] off);
    case (off)
      3'd1:    return {29'd0, m_ctrl};
      3'd2:    return {29'd0, m_perr, m_ovf, rx_ready};
      3'd3:    return {29'd0, m_inten};
      default: return 32'd0;
    endcase
  endfunction

  task automatic push(input string name, input bit is_read, input logic [31:0] rdata,
                      input logic slverr, input int waits);
    exp_t e;
    e.name = name; e.is_read = is_read; e.rdata = rdata; e.slverr = slverr; e.waits = waits;
    exp_q.push_back(e);
  endtask

  task automatic apb(input bit wr, input logic [4:0] addr, input logic [31:0] wdata);
    int n;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!PREADY && n < 20);
    checks++;
    if (!PREADY) begin
      failures++;
      $display("FAIL apb_timeout addr=0x%0h pready=%0b required=1", addr, PREADY);
      if (exp_q.size() > 0) exp_q.delete(0);
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic idle_check();
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("irq_level", irq, exp_irq());
    chk("cfg_out", {parity_odd0_even1, parity_en, data_bits}, m_ctrl);
    chk("pop_count", obs_pops, m_pops);
  endtask

  task automatic rd_reg(input logic [4:0] addr);
    logic [2:0] off;
    off = addr[4:2];
    if (off >= 3'd4) push("rd_unmapped", 1'b1, 32'd0, 1'b1, 0);
    else             push("rd_reg", 1'b1, model_read(off), 1'b0, 0);
    apb(1'b0, addr, 32'd0);
    idle_check();
  endtask

  task automatic wr_reg(input logic [4:0] addr, input logic [31:0] wdata);
    logic [2:0] off;
    off = addr[4:2];
    push("wr_reg", 1'b0, 32'd0, (off >= 3'd4), 0);
    apb(1'b1, addr, wdata);
    case (off)
      3'd1: m_ctrl = wdata[2:0];
      3'd2: begin
        if (wdata[1]) m_ovf = 1'b0;
        if (wdata[2]) m_perr = 1'b0;
      end
      3'd3: m_inten = c_irq_en ? wdata[2:0] : 3'b000;
      default: ;
    endcase
    idle_check();
  endtask

  // Receiver answers a pop after lat cycles; lat outside 1..RD_TIMEOUT means a timeout
  task automatic rx_read(input bit rdy, input int lat, input logic [7:0] d);
    rx_ready = rdy; rx_lat = lat; rx_data = d;
    if (!rdy) begin
      push("rx_nordy", 1'b1, 32'd0, 1'b0, 0);
    end else begin
      m_pops++;
      if (lat >= 1 && lat <= int'(c_rd_to)) push("rx_data", 1'b1, 32'h100 + {24'd0, d}, 1'b0, lat);
      else                                  push("rx_tmo", 1'b1, 32'd0, 1'b1, int'(c_rd_to));
    end
    apb(1'b0, {3'd0, 2'($urandom)}, 32'd0);
    repeat (5) @(posedge PCLK);
    idle_check();
  endtask

  task automatic pulse(input bit o, input bit p);
    @(posedge PCLK); #1;
    overflow = o; parity_err = p;
    @(posedge PCLK); #1;
    overflow = 1'b0; parity_err = 1'b0;
    if (o) m_ovf = 1'b1;
    if (p) m_perr = 1'b1;
    idle_check();
  endtask

  task automatic model_reset();
    m_ctrl = 3'b001; m_inten = 3'b000; m_ovf = 1'b0; m_perr = 1'b0;
  endtask

  task automatic w1c_vs_set();
    rx_ready = 1'b0;
    wr_reg(5'h0C, 32'h2);
    wr_reg(5'h08, 32'h6);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h08; PWDATA = 32'h2;
    push("w1c_vs_set", 1'b0, 32'd0, 1'b0, 0);
    @(posedge PCLK); #1;
    PENABLE = 1'b1; overflow = 1'b1;
    @(negedge PCLK);
    chk("irq_before_set", irq, 1'b0);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; overflow = 1'b0;
    m_ovf = 1'b1;
    @(negedge PCLK);
    chk("irq_lat0", irq, 1'b0);
    @(negedge PCLK);
    chk("irq_lat1", irq, exp_irq());
    rd_reg(5'h08);
  endtask

  task automatic reset_in_wait();
    rx_ready = 1'b1; rx_lat = 0;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 5'h00;
    m_pops++;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("rst_pready", PREADY, 1'b1);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_pslverr", PSLVERR, 1'b0);
    chk("rst_pop", rx_data_reg_rd, 1'b0);
    chk("rst_irq", irq, 1'b0);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    model_reset();
    repeat (10) @(posedge PCLK);
    @(negedge PCLK);
    chk("pops_after_reset", obs_pops, m_pops);
    rx_ready = 1'b0;
    idle_check();
  endtask

  always @(negedge PCLK) begin
    if (rx_data_reg_rd === 1'b1) obs_pops <= obs_pops + 1;
  end

  initial begin : receiver
    forever begin
      @(negedge PCLK);
      if (rx_data_reg_rd === 1'b1 && rx_lat > 0) begin
        repeat (rx_lat) @(posedge PCLK);
        #1 rx_data_read_valid = 1'b1;
        @(posedge PCLK);
        #1 rx_data_read_valid = 1'b0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge PCLK);
      if (!PRESET && PSEL && PENABLE) begin
        if (!PREADY) begin
          mon_waits++;
          chk("prdata_in_wait", PRDATA, 32'd0);
        end else if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_completion addr=0x%0h actual=completion required=none", PADDR);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.is_read) chk({mon_e.name, "_prdata"}, PRDATA, mon_e.rdata);
          chk({mon_e.name, "_pslverr"}, PSLVERR, mon_e.slverr);
          chk({mon_e.name, "_waits"}, mon_waits, mon_e.waits);
          mon_waits = 0;
        end
      end else begin
        mon_waits = 0;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [2:0] off;
    PRESET = 1'b1; PSEL = 1'b1; PENABLE = 1'b1; PADDR = 5'h04;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("reset_pready", PREADY, 1'b1);
    chk("reset_prdata", PRDATA, 32'd0);
    chk("reset_pslverr", PSLVERR, 1'b0);
    chk("reset_irq", irq, 1'b0);
    chk("reset_pop", rx_data_reg_rd, 1'b0);
    chk("reset_cfg", {parity_odd0_even1, parity_en, data_bits}, 3'b001);
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;

    rd_reg(5'h04);
    rx_read(1'b1, 2, 8'hA5);
    rx_read(1'b0, 2, 8'h3C);
    rx_read(1'b1, 0, 8'h77);
    rd_reg(5'h04);
    w1c_vs_set();
    rd_reg(5'h14);
    wr_reg(5'h14, 32'hFFFF_FFFF);
    wr_reg(5'h00, 32'h0000_01FF);
    reset_in_wait();
    rd_reg(5'h04);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 7))
        0, 1: rx_read(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)), 8'($urandom));
        2:    wr_reg({3'd1, 2'($urandom)}, $urandom);
        3:    wr_reg({3'd3, 2'($urandom)}, $urandom);
        4:    wr_reg({3'd2, 2'($urandom)}, $urandom);
        5:    rd_reg({3'($urandom_range(1, 7)), 2'($urandom)});
        6:    pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: begin
          off = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(4, 7)) : 3'd0;
          wr_reg({off, 2'($urandom)}, $urandom);
        end
      endcase
    end

    repeat (4) @(posedge PCLK);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
